mem_port_arbiter: RTL and testbench

//  Shares the single unified memory port between instruction fetch (IF) and the MEM stage data access.

---
 rtl/mem_port_arbiter_if.sv | 56 +++++
 rtl/mem_port_arbiter.sv | 255 +++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the IF request, MEM-stage data request, status and unified memory
// bus signals shared by mem_port_arbiter and its surroundings.
//   slave  : arbiter view (takes requests and mem responses, drives done/bus)
//   master : requester/memory view (drives requests and mem responses)
// Signals:
//   if_req/if_addr -> if_rdata/if_done                    instruction fetch
//   d_req/d_wr/d_addr/d_wdata/d_wmask/d_rmask -> d_rdata/d_done   data access
//   err, stall_if, stall_mem                              status to pipeline
//   memCe/memWr/memRr/memAddr/wtData/w_mask/r_mask        memory bus
//   rdData/mem_ack                                        memory response
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;

  logic        d_req;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wmask;
  logic [3:0]  d_rmask;
  logic [31:0] d_rdata;
  logic        d_done;

  logic        err;
  logic        stall_if;
  logic        stall_mem;

  logic        memCe;
  logic        memWr;
  logic        memRr;
  logic [31:0] memAddr;
  logic [31:0] wtData;
  logic [3:0]  w_mask;
  logic [3:0]  r_mask;
  logic [31:0] rdData;
  logic        mem_ack;

  modport slave (
    input  if_req, if_addr, d_req, d_wr, d_addr, d_wdata, d_wmask, d_rmask,
           rdData, mem_ack,
    output if_rdata, if_done, d_rdata, d_done, err, stall_if, stall_mem,
           memCe, memWr, memRr, memAddr, wtData, w_mask, r_mask
  );

  modport master (
    output if_req, if_addr, d_req, d_wr, d_addr, d_wdata, d_wmask, d_rmask,
           rdData, mem_ack,
    input  if_rdata, if_done, d_rdata, d_done, err, stall_if, stall_mem,
           memCe, memWr, memRr, memAddr, wtData, w_mask, r_mask
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one unified memory port between instruction fetch and the MEM-stage
// data access. A registered FSM (IDLE -> BUS_I/BUS_D -> RESP -> IDLE) grants
// one requester, holds the bus fields stable until mem_ack (or timeout), then
// returns a one-cycle done pulse with read data. Data wins ties.
// Parameters:
//   TIMEOUT      : BUS cycles without mem_ack before abort with err (0 = off)
//   STARVE_LIMIT : consecutive data grants allowed while IF waits
// Optional feature macro:
//   ARB_STARVE_GUARD_EN : when defined, IF is forced through after
//                         STARVE_LIMIT back-to-back data grants.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : mem_port_arbiter_if.slave (requests, status, memory bus)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int TIMEOUT      = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS_I = 2'd1,
    ST_BUS_D = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TO_W-1:0] r_to_cnt;

  // Registered outputs and their next values
  logic        r_mem_ce,   w_mem_ce;
  logic        r_mem_wr,   w_mem_wr;
  logic        r_mem_rr,   w_mem_rr;
  logic [31:0] r_mem_addr, w_mem_addr;
  logic [31:0] r_wt_data,  w_wt_data;
  logic [3:0]  r_w_mask,   w_w_mask;
  logic [3:0]  r_r_mask,   w_r_mask;
  logic        r_if_done,  w_if_done;
  logic        r_d_done,   w_d_done;
  logic        r_err,      w_err;
  logic [31:0] r_if_rdata, w_if_rdata;
  logic [31:0] r_d_rdata,  w_d_rdata;

  logic w_grant_d;
  logic w_grant_i;
  logic w_force_if;
  logic w_to_hit;
  logic w_finish;

  // Data has priority unless the starve guard forces IF through.
  assign w_grant_d = bus.d_req & ~w_force_if;
  assign w_grant_i = bus.if_req & ~w_grant_d;
  assign w_finish  = bus.mem_ack | w_to_hit;

  // The counter reads TIMEOUT-1 during the TIMEOUT-th BUS cycle.
  generate
    if (TIMEOUT > 0) begin : g_timeout
      assign w_to_hit = (r_to_cnt == TO_W'(TIMEOUT - 1));
    end else begin : g_no_timeout
      assign w_to_hit = 1'b0;
    end
  endgenerate

`ifdef ARB_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  logic [SC_W-1:0] r_starve_cnt;

  assign w_force_if = bus.if_req & (r_starve_cnt == SC_W'(STARVE_LIMIT));

  // Count data grants made while IF waits; any IF grant clears the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve_cnt <= '0;
    end else if (r_state == ST_IDLE && w_grant_d && bus.if_req &&
                 r_starve_cnt != SC_W'(STARVE_LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + SC_W'(1'b1);
    end else if (r_state == ST_IDLE && w_grant_i) begin
      r_starve_cnt <= '0;
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end
`else
  assign w_force_if = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_d) begin
          w_state_nxt = ST_BUS_D;
        end else if (w_grant_i) begin
          w_state_nxt = ST_BUS_I;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUS_I, ST_BUS_D: begin
        if (w_finish) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Timeout counter: zero on BUS entry, advances each BUS cycle without ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_to_cnt <= '0;
    end else if ((r_state == ST_BUS_I || r_state == ST_BUS_D) && !bus.mem_ack) begin
      r_to_cnt <= r_to_cnt + TO_W'(1'b1);
    end else begin
      r_to_cnt <= r_to_cnt;
    end
  end

  // Next values of the registered outputs; everything is 0 unless set.
  always_comb begin
    w_mem_ce   = 1'b0;
    w_mem_wr   = 1'b0;
    w_mem_rr   = 1'b0;
    w_mem_addr = 32'd0;
    w_wt_data  = 32'd0;
    w_w_mask   = 4'd0;
    w_r_mask   = 4'd0;
    w_if_done  = 1'b0;
    w_d_done   = 1'b0;
    w_err      = 1'b0;
    w_if_rdata = 32'd0;
    w_d_rdata  = 32'd0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_d) begin
          w_mem_ce   = 1'b1;
          w_mem_wr   = bus.d_wr;
          w_mem_rr   = ~bus.d_wr;
          w_mem_addr = bus.d_addr;
          w_wt_data  = bus.d_wdata;
          w_w_mask   = bus.d_wmask;
          w_r_mask   = bus.d_rmask;
        end else if (w_grant_i) begin
          w_mem_ce   = 1'b1;
          w_mem_rr   = 1'b1;
          w_mem_addr = bus.if_addr;
          w_r_mask   = 4'hF;
        end else begin
          w_mem_ce   = 1'b0;
        end
      end
      ST_BUS_I, ST_BUS_D: begin
        if (w_finish) begin
          // Bus drops for RESP; an ack in the timeout cycle still wins.
          w_err = ~bus.mem_ack;
          if (r_state == ST_BUS_I) begin
            w_if_done  = 1'b1;
            w_if_rdata = bus.mem_ack ? bus.rdData : 32'd0;
          end else begin
            w_d_done   = 1'b1;
            w_d_rdata  = (bus.mem_ack && !r_mem_wr) ? bus.rdData : 32'd0;
          end
        end else begin
          w_mem_ce   = r_mem_ce;
          w_mem_wr   = r_mem_wr;
          w_mem_rr   = r_mem_rr;
          w_mem_addr = r_mem_addr;
          w_wt_data  = r_wt_data;
          w_w_mask   = r_w_mask;
          w_r_mask   = r_r_mask;
        end
      end
      ST_RESP: begin
        w_mem_ce = 1'b0;
      end
      default: begin
        w_mem_ce = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_ce   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_mem_rr   <= 1'b0;
      r_mem_addr <= 32'd0;
      r_wt_data  <= 32'd0;
      r_w_mask   <= 4'd0;
      r_r_mask   <= 4'd0;
      r_if_done  <= 1'b0;
      r_d_done   <= 1'b0;
      r_err      <= 1'b0;
      r_if_rdata <= 32'd0;
      r_d_rdata  <= 32'd0;
    end else begin
      r_mem_ce   <= w_mem_ce;
      r_mem_wr   <= w_mem_wr;
      r_mem_rr   <= w_mem_rr;
      r_mem_addr <= w_mem_addr;
      r_wt_data  <= w_wt_data;
      r_w_mask   <= w_w_mask;
      r_r_mask   <= w_r_mask;
      r_if_done  <= w_if_done;
      r_d_done   <= w_d_done;
      r_err      <= w_err;
      r_if_rdata <= w_if_rdata;
      r_d_rdata  <= w_d_rdata;
    end
  end

  assign bus.memCe    = r_mem_ce;
  assign bus.memWr    = r_mem_wr;
  assign bus.memRr    = r_mem_rr;
  assign bus.memAddr  = r_mem_addr;
  assign bus.wtData   = r_wt_data;
  assign bus.w_mask   = r_w_mask;
  assign bus.r_mask   = r_r_mask;
  assign bus.if_done  = r_if_done;
  assign bus.d_done   = r_d_done;
  assign bus.err      = r_err;
  assign bus.if_rdata = r_if_rdata;
  assign bus.d_rdata  = r_d_rdata;

  // Stall while a request is pending and its done pulse is not out yet.
  assign bus.stall_if  = bus.if_req & ~r_if_done;
  assign bus.stall_mem = bus.d_req & ~r_d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Transaction-level bench: each round picks the winner from the arbitration
// rules, plays a memory with a chosen ack delay, and checks bus fields,
// stalls, done/err pulses and returned data against that expectation.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
  localparam int TIMEOUT      = 16;
  localparam int STARVE_LIMIT = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   starve_cnt;

  mem_port_arbiter_if u_if ();

  mem_port_arbiter #(
    .TIMEOUT      (TIMEOUT),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic raise_if(input logic [31:0] addr);
    u_if.if_req  = 1'b1;
    u_if.if_addr = addr;
  endtask

  task automatic raise_d(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wm, input logic [3:0] rm);
    u_if.d_req   = 1'b1;
    u_if.d_wr    = wr;
    u_if.d_addr  = addr;
    u_if.d_wdata = wdata;
    u_if.d_wmask = wm;
    u_if.d_rmask = rm;
  endtask

  task automatic raise_d_rand();
    raise_d(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom), 4'($urandom));
  endtask

  // Called just after a rising edge with the DUT idle; runs one transfer.
  task automatic do_round(input int dly, input logic [31:0] ack_data);
    logic        gd;
    logic        force_if;
    logic        e_wr;
    logic        got_ack;
    logic [31:0] e_addr;
    logic [31:0] e_wt;
    logic [31:0] cap;
    logic [31:0] e_rd;
    logic [3:0]  e_wm;
    logic [3:0]  e_rm;

    force_if = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    force_if = (starve_cnt == STARVE_LIMIT) && u_if.if_req;
`endif
    gd = u_if.d_req && !force_if;
    if (gd) begin
      e_wr   = u_if.d_wr;
      e_addr = u_if.d_addr;
      e_wt   = u_if.d_wdata;
      e_wm   = u_if.d_wmask;
      e_rm   = u_if.d_rmask;
      if (u_if.if_req) starve_cnt++;
    end else begin
      e_wr   = 1'b0;
      e_addr = u_if.if_addr;
      e_wt   = 32'd0;
      e_wm   = 4'd0;
      e_rm   = 4'hF;
      starve_cnt = 0;
    end

    @(negedge clk);
    check_val("idle_bus", 32'({u_if.memCe, u_if.memWr, u_if.memRr}), 32'd0);
    check_val("idle_stall", 32'({u_if.stall_if, u_if.stall_mem}), 32'({u_if.if_req, u_if.d_req}));
    check_val("idle_done", 32'({u_if.if_done, u_if.d_done, u_if.err}), 32'd0);

    @(posedge clk);
    #1;
    got_ack = 1'b0;
    cap     = 32'd0;
    for (int k = 1; k <= TIMEOUT + 8; k++) begin
      u_if.mem_ack = (k == dly);
      u_if.rdData  = (k == dly) ? ack_data : $urandom;
      // Changes by the granted requester must not reach the bus.
      if (gd) begin
        u_if.d_addr  = $urandom;
        u_if.d_wdata = $urandom;
        u_if.d_wmask = 4'($urandom);
      end else begin
        u_if.if_addr = $urandom;
      end
      @(negedge clk);
      check_val("bus_ctl", 32'({u_if.memCe, u_if.memWr, u_if.memRr, u_if.w_mask, u_if.r_mask}),
                32'({1'b1, e_wr, ~e_wr, e_wm, e_rm}));
      check_val("bus_addr", u_if.memAddr, e_addr);
      check_val("bus_wdata", u_if.wtData, e_wt);
      check_val("bus_stall", 32'({u_if.stall_if, u_if.stall_mem, u_if.if_done, u_if.d_done}),
                32'({u_if.if_req, u_if.d_req, 2'b00}));
      if (k == dly) begin
        got_ack = 1'b1;
        cap     = ack_data;
        break;
      end
      if (TIMEOUT != 0 && k == TIMEOUT) break;
      @(posedge clk);
      #1;
    end

    @(posedge clk);
    #1;
    u_if.mem_ack = 1'b0;
    @(negedge clk);
    e_rd = (got_ack && !e_wr) ? cap : 32'd0;
    check_val("resp_done", 32'({u_if.if_done, u_if.d_done}), gd ? 32'd1 : 32'd2);
    check_val("resp_err", 32'(u_if.err), 32'(!got_ack));
    check_val("resp_rdata", gd ? u_if.d_rdata : u_if.if_rdata, e_rd);
    check_val("resp_other_rdata", gd ? u_if.if_rdata : u_if.d_rdata, 32'd0);
    check_val("resp_bus", 32'({u_if.memCe, u_if.memWr, u_if.memRr, u_if.w_mask, u_if.r_mask}) |
              u_if.memAddr | u_if.wtData, 32'd0);
    check_val("resp_stall", 32'({u_if.stall_if, u_if.stall_mem}),
              gd ? 32'({u_if.if_req, 1'b0}) : 32'({1'b0, u_if.d_req}));

    @(posedge clk);
    #1;
    if (gd) u_if.d_req = 1'b0;
    else    u_if.if_req = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    starve_cnt = 0;
    rst          = 1'b0;
    u_if.if_req  = 1'b0;
    u_if.if_addr = 32'd0;
    u_if.d_req   = 1'b0;
    u_if.d_wr    = 1'b0;
    u_if.d_addr  = 32'd0;
    u_if.d_wdata = 32'd0;
    u_if.d_wmask = 4'd0;
    u_if.d_rmask = 4'd0;
    u_if.rdData  = 32'd0;
    u_if.mem_ack = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_ctl", 32'({u_if.memCe, u_if.memWr, u_if.memRr, u_if.w_mask, u_if.r_mask,
                             u_if.if_done, u_if.d_done, u_if.err, u_if.stall_if, u_if.stall_mem}), 32'd0);
    check_val("rst_addr", u_if.memAddr | u_if.wtData, 32'd0);
    check_val("rst_rdata", u_if.if_rdata | u_if.d_rdata, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Lone load, ack in first bus cycle.
    raise_d(1'b0, 32'h0000_0100, 32'd0, 4'd0, 4'hF);
    do_round(1, 32'hDEAD_BEEF);

    // Tie: data first, IF afterwards.
    raise_if(32'h0000_2000);
    raise_d(1'b0, 32'h0000_0300, 32'd0, 4'd0, 4'hF);
    do_round(2, $urandom);
    do_round(1, $urandom);

    // Slow store.
    raise_d(1'b1, 32'h0000_0400, 32'h1234_5678, 4'b0011, 4'd0);
    do_round(5, $urandom);

    // Timeout with no ack, then ack on the last allowed cycle.
    raise_if(32'h0000_0500);
    do_round(TIMEOUT + 4, 32'd0);
    raise_if(32'h0000_0600);
    do_round(TIMEOUT, 32'hCAFE_F00D);

    // Both requests held continuously.
    raise_if(32'h0000_0700);
    for (int r = 0; r < 12; r++) begin
      if (!u_if.d_req) raise_d_rand();
      do_round($urandom_range(1, 3), $urandom);
    end

    // Random traffic.
    for (int r = 0; r < 120; r++) begin
      if (!u_if.if_req && $urandom_range(0, 1) == 1) raise_if($urandom);
      if (!u_if.d_req && $urandom_range(0, 1) == 1) raise_d_rand();
      if (!u_if.if_req && !u_if.d_req) raise_d_rand();
      do_round($urandom_range(1, TIMEOUT + 4), $urandom);
    end

    // Reset in the middle of a data transfer.
    u_if.if_req = 1'b0;
    if (!u_if.d_req) raise_d_rand();
    @(posedge clk);
    #1;
    @(negedge clk);
    check_val("rst_pre_ce", 32'(u_if.memCe), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_val("rst_async", 32'({u_if.memCe, u_if.d_done, u_if.err}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    starve_cnt = 0;
    do_round(2, $urandom);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
